bias_add_stage: RTL and testbench

Downstream consumer of the bias ROM. Receives one beat of PE_Num signed accumulator sums per output channel and drives the bias ROM read address for that channel. It adds the returned per-PE bias, rescales and saturates each lane to dwidth, and presents the result on a valid/ready stream toward the pooling/write-back stage. The pipeline is two-deep, with full backpressure, and the ROM address is held stable while the block is stalled.

---
 rtl/bias_add_stage_if.sv | 28 ++
 rtl/bias_add_stage.sv | 127 ++++++++++++
 tb/tb_bias_add_stage.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bias_add_stage_if.sv
// Stream and bias-ROM signal bundle for bias_add_stage.
// slave = the stage itself, master = the producer/consumer/ROM side.
interface bias_add_stage_if #(
   parameter int dwidth = 16,
   parameter int PE_Num = 8,
   parameter int awidth = 32
);
   logic                       psum_valid;
   logic                       psum_ready;
   logic [PE_Num*awidth-1:0]   psum;
   logic [4:0]                 psum_ch;
   logic [4:0]                 rom_bias_raddr;
   logic [PE_Num*dwidth-1:0]   rom_bias;
   logic                       out_valid;
   logic                       out_ready;
   logic [PE_Num*dwidth-1:0]   out_data;
   logic [15:0]                sat_count;

   modport slave (
      input  psum_valid, psum, psum_ch, rom_bias, out_ready,
      output psum_ready, rom_bias_raddr, out_valid, out_data, sat_count
   );

   modport master (
      output psum_valid, psum, psum_ch, rom_bias, out_ready,
      input  psum_ready, rom_bias_raddr, out_valid, out_data, sat_count
   );
endinterface

// File: rtl/bias_add_stage.sv
// Two-stage bias add / rescale / saturate pipeline fed by a 1-cycle bias ROM.
// Optional macro BIAS_ADD_RELU_EN zeroes negative lanes after the clamp.
module bias_add_stage #(
   parameter int dwidth    = 16,
   parameter int PE_Num    = 8,
   parameter int awidth    = 32,
   parameter int OUT_SHIFT = 8
) (
   input logic             clk,
   input logic             rst,
   bias_add_stage_if.slave bus
);
   localparam int dw_tot = PE_Num*dwidth;
   localparam int aw_tot = PE_Num*awidth;

   localparam logic signed [awidth:0] lane_max_c =
      $signed({{(awidth-dwidth+2){1'b0}}, {(dwidth-1){1'b1}}});
   localparam logic signed [awidth:0] lane_min_c =
      $signed({{(awidth-dwidth+2){1'b1}}, {(dwidth-1){1'b0}}});

   logic [aw_tot-1:0] s1_psum_r;
   logic              s1_valid_r;
   logic [4:0]        held_ch_r;
   logic              out_valid_r;
   logic [dw_tot-1:0] out_data_r;
   logic [15:0]       sat_count_r;

   logic              accept_s;
   logic              s1_advance_s;
   logic              psum_ready_s;
   logic [dw_tot-1:0] result_s;
   logic              any_sat_s;

   // Lane result in [dwidth-1:0], saturation flag in [dwidth].
   function automatic logic [dwidth:0] lane_calc(
      input logic [awidth-1:0] p,
      input logic [dwidth-1:0] b
   );
      logic signed [awidth:0] t;
      logic signed [awidth:0] r;
      logic [dwidth:0]        res;
      t = {p[awidth-1], p} + {{(awidth+1-dwidth){b[dwidth-1]}}, b};
      r = t >>> OUT_SHIFT;
      if (r > lane_max_c) begin
         res = {1'b1, lane_max_c[dwidth-1:0]};
      end else if (r < lane_min_c) begin
`ifdef BIAS_ADD_RELU_EN
         res = {1'b0, {dwidth{1'b0}}};
`else
         res = {1'b1, lane_min_c[dwidth-1:0]};
`endif
      end else begin
`ifdef BIAS_ADD_RELU_EN
         if (r[awidth]) begin
            res = {1'b0, {dwidth{1'b0}}};
         end else begin
            res = {1'b0, r[dwidth-1:0]};
         end
`else
         res = {1'b0, r[dwidth-1:0]};
`endif
      end
      return res;
   endfunction

   assign accept_s     = bus.psum_valid & psum_ready_s;
   assign s1_advance_s = s1_valid_r & (~out_valid_r | bus.out_ready);
   assign psum_ready_s = ~s1_valid_r | s1_advance_s;

   // Address follows the incoming channel on accept, otherwise stays on the S1 beat.
   assign bus.rom_bias_raddr = accept_s ? bus.psum_ch : held_ch_r;
   assign bus.psum_ready     = psum_ready_s;
   assign bus.out_valid      = out_valid_r;
   assign bus.out_data       = out_data_r;
   assign bus.sat_count      = sat_count_r;

   // Per-lane bias add, rescale and clamp of the S1 beat.
   always_comb begin : lane_math
      logic [dwidth:0] lane_v;
      lane_v    = {(dwidth+1){1'b0}};
      result_s  = {dw_tot{1'b0}};
      any_sat_s = 1'b0;
      for (int i = 0; i < PE_Num; i++) begin
         lane_v = lane_calc(s1_psum_r[i*awidth +: awidth], bus.rom_bias[i*dwidth +: dwidth]);
         result_s[i*dwidth +: dwidth] = lane_v[dwidth-1:0];
         any_sat_s = any_sat_s | lane_v[dwidth];
      end
   end

   // S1: capture accepted beat and its channel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_psum_r  <= {aw_tot{1'b0}};
         s1_valid_r <= 1'b0;
         held_ch_r  <= 5'd0;
      end else if (accept_s) begin
         s1_psum_r  <= bus.psum;
         s1_valid_r <= 1'b1;
         held_ch_r  <= bus.psum_ch;
      end else if (s1_advance_s) begin
         s1_valid_r <= 1'b0;
      end else begin
         s1_valid_r <= s1_valid_r;
      end
   end

   // S2: output register and saturation event counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_data_r  <= {dw_tot{1'b0}};
         sat_count_r <= 16'd0;
      end else if (s1_advance_s) begin
         out_valid_r <= 1'b1;
         out_data_r  <= result_s;
         if (any_sat_s && (sat_count_r != 16'hFFFF)) begin
            sat_count_r <= sat_count_r + 16'd1;
         end else begin
            sat_count_r <= sat_count_r;
         end
      end else if (bus.out_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end
endmodule

// File: tb/tb_bias_add_stage.sv
// Randomized scoreboard bench for bias_add_stage with a behavioural bias ROM.
module tb_bias_add_stage;
   localparam int DW = 16;
   localparam int PE = 8;
   localparam int AW = 32;
   localparam int SH = 8;

   typedef struct {
      logic [PE*DW-1:0] data;
      bit               sat;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   bias_add_stage_if #(.dwidth(DW), .PE_Num(PE), .awidth(AW)) bif();

   bias_add_stage #(.dwidth(DW), .PE_Num(PE), .awidth(AW), .OUT_SHIFT(SH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   always #5 clk = ~clk;

   logic [PE*DW-1:0] bias_mem [32];
   exp_t             sb [$];
   int               hs_cyc [$];
   int               tests = 0;
   int               fails = 0;
   int               cyc = 0;
   int               exp_sat = 0;
   int               last_acc_cyc = 0;
   int               first_out_cyc = -1;
   logic [4:0]       last_ch = 5'd0;
   bit               prev_hold = 1'b0;
   logic [PE*DW-1:0] prev_data;
   bit               saw_stall = 1'b0;
   bit               rec_hs = 1'b0;
   bit               rand_ready = 1'b0;

   // registered-read bias ROM
   always @(posedge clk) bif.rom_bias <= bias_mem[bif.rom_bias_raddr];
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (rand_ready) bif.out_ready = ($urandom_range(0, 3) != 0);
   end

   function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endfunction

   // Reference: exact integer add, floor division by 2^SH, clamp, optional ReLU.
   function automatic exp_t model(input logic [PE*AW-1:0] p, input logic [4:0] ch);
      exp_t e;
      longint a, b, t, r, dv, hi, lo;
      logic [PE*DW-1:0] bv;
      dv = 64'sd1 <<< SH;
      hi = (64'sd1 <<< (DW-1)) - 64'sd1;
      lo = -hi - 64'sd1;
      bv = bias_mem[ch];
      e.sat = 1'b0;
      e.data = {(PE*DW){1'b0}};
      for (int i = 0; i < PE; i++) begin
         a = longint'($signed(p[i*AW +: AW]));
         b = longint'($signed(bv[i*DW +: DW]));
         t = a + b;
         if (t >= 0) r = t / dv;
         else r = -((-t + dv - 64'sd1) / dv);
         if (r > hi) begin
            r = hi;
            e.sat = 1'b1;
         end else if (r < lo) begin
            r = lo;
`ifndef BIAS_ADD_RELU_EN
            e.sat = 1'b1;
`endif
         end
`ifdef BIAS_ADD_RELU_EN
         if (r < 0) r = 0;
`endif
         e.data[i*DW +: DW] = r[DW-1:0];
      end
      return e;
   endfunction

   function automatic logic [PE*AW-1:0] rand_psum();
      logic [PE*AW-1:0] p;
      int v;
      for (int i = 0; i < PE; i++) begin
         if ($urandom_range(0, 3) == 0) v = int'($urandom());
         else v = int'($urandom_range(0, 8388607)) - 4194304;
         p[i*AW +: AW] = v;
      end
      return p;
   endfunction

   function automatic logic [PE*AW-1:0] fill_psum(input logic [AW-1:0] v);
      logic [PE*AW-1:0] p;
      for (int i = 0; i < PE; i++) p[i*AW +: AW] = v;
      return p;
   endfunction

   task automatic send_beat(input logic [PE*AW-1:0] p, input logic [4:0] ch);
      int waited;
      waited = 0;
      bif.psum = p;
      bif.psum_ch = ch;
      bif.psum_valid = 1'b1;
      @(negedge clk);
      while (!bif.psum_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!bif.psum_ready) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: ch %0d got no psum_ready, required ready within 200 cycles", ch);
      end else begin
         chk("raddr_accept", bif.rom_bias_raddr, ch);
         sb.push_back(model(p, ch));
         last_ch = ch;
         last_acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      bif.psum_valid = 1'b0;
      bif.out_ready = 1'b1;
      while (sb.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: got %0d pending results, required 0", sb.size());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Monitor: pops the scoreboard on every output handshake and checks hold/address rules.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_hold = 1'b0;
         exp_sat = 0;
      end else begin
         if (prev_hold) begin
            chk("hold_valid", bif.out_valid, 1);
            chk("hold_data", bif.out_data, prev_data);
         end
         if (bif.psum_valid && !bif.psum_ready) saw_stall = 1'b1;
         if (!(bif.psum_valid && bif.psum_ready)) chk("raddr_held", bif.rom_bias_raddr, last_ch);
         if (bif.out_valid && bif.out_ready) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL spurious_out: got out_data %h, required no output", bif.out_data);
            end else begin
               e = sb.pop_front();
               chk("out_data", bif.out_data, e.data);
               if (e.sat && exp_sat < 65535) exp_sat++;
               chk("sat_count", bif.sat_count, exp_sat);
               if (rec_hs) hs_cyc.push_back(cyc);
               if (first_out_cyc < 0) first_out_cyc = cyc;
            end
         end
         prev_hold = bif.out_valid && !bif.out_ready;
         prev_data = bif.out_data;
      end
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation still running, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [PE*AW-1:0] p;
      for (int c = 0; c < 32; c++)
         for (int i = 0; i < PE; i++) bias_mem[c][i*DW +: DW] = 16'($urandom());
      for (int i = 0; i < PE; i++) begin
         bias_mem[3][i*DW +: DW] = 16'h0100;
         bias_mem[7][i*DW +: DW] = 16'h0001;
      end
      rst = 1'b1;
      bif.psum_valid = 1'b0;
      bif.psum = {(PE*AW){1'b0}};
      bif.psum_ch = 5'd0;
      bif.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_psum_ready", bif.psum_ready, 1);
      chk("rst_out_valid", bif.out_valid, 0);
      chk("rst_out_data", bif.out_data, 0);
      chk("rst_raddr", bif.rom_bias_raddr, 0);
      chk("rst_sat_count", bif.sat_count, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // single beat, directed values, latency
      first_out_cyc = -1;
      send_beat(fill_psum(32'h0000_1200), 5'd3);
      drain();
      chk("latency", first_out_cyc - last_acc_cyc, 2);

      // saturation at both bounds
      p = {(PE*AW){1'b0}};
      p[AW-1:0] = 32'h7FFF_FF00;
      send_beat(p, 5'd3);
      p[AW-1:0] = 32'h8000_0100;
      send_beat(p, 5'd3);
      drain();
`ifdef BIAS_ADD_RELU_EN
      chk("sat_total", bif.sat_count, 1);
`else
      chk("sat_total", bif.sat_count, 2);
`endif

      // ReLU-relevant small values around zero
      send_beat(fill_psum(32'hFFFF_FB00), 5'd7);
      send_beat(fill_psum(32'h0000_0500), 5'd7);
      drain();

      // backpressure: out_ready low in cycles 3..6 of a 5-beat burst
      saw_stall = 1'b0;
      fork
         begin
            for (int c = 0; c < 5; c++) send_beat(rand_psum(), 5'(c));
            bif.psum_valid = 1'b0;
         end
         begin
            repeat (2) @(posedge clk);
            #1 bif.out_ready = 1'b0;
            repeat (4) @(posedge clk);
            #1 bif.out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_stall_seen", saw_stall, 1);

      // continuous stream over all channels
      hs_cyc.delete();
      rec_hs = 1'b1;
      for (int c = 0; c < 32; c++) send_beat(rand_psum(), 5'(c));
      drain();
      rec_hs = 1'b0;
      chk("stream_count", hs_cyc.size(), 32);
      if (hs_cyc.size() == 32) chk("stream_span", hs_cyc[31] - hs_cyc[0], 31);

      // random traffic with random backpressure
      rand_ready = 1'b1;
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            bif.psum_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         send_beat(rand_psum(), 5'($urandom_range(0, 31)));
      end
      rand_ready = 1'b0;
      drain();

      // reset while both stages hold beats
      bif.out_ready = 1'b0;
      send_beat(rand_psum(), 5'd1);
      send_beat(rand_psum(), 5'd2);
      bif.psum_valid = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", bif.out_valid, 0);
      chk("midrst_psum_ready", bif.psum_ready, 1);
      sb.delete();
      last_ch = 5'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bif.out_ready = 1'b1;
      @(posedge clk);
      #1;
      send_beat(rand_psum(), 5'd9);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
